// File: rtl/ram_even_banks.sv
// Four independent 128x26 single-port RAMs (even, odd, even1, odd1) with a
// shared 5/3 lifting write datapath, enabled by defining RAM_EVEN_LIFT_EN.
module ram_even_banks (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  pix_addr_even,
  input  logic [6:0]  pix_addr_odd,
  input  logic [6:0]  pix_addr_even1,
  input  logic [6:0]  pix_addr_odd1,
  input  logic        pix_we_even,
  input  logic        pix_we_odd,
  input  logic        pix_we_even1,
  input  logic        pix_we_odd1,
  input  logic [25:0] pix_din_even,
  input  logic [25:0] pix_din_odd,
  input  logic [25:0] pix_din_even1,
  input  logic [25:0] pix_din_odd1,
  output logic [25:0] pix_dout_even,
  output logic [25:0] pix_dout_odd,
  output logic [25:0] pix_dout_even1,
  output logic [25:0] pix_dout_odd1,
  input  logic [25:0] pix_left,
  input  logic [25:0] pix_right,
  input  logic [25:0] pix_left1,
  input  logic [25:0] pix_right1,
  input  logic        pix_even_odd,
  input  logic        pix_fwd_inv,
  input  logic        pix_p
);

  logic [6:0]  addr [4];
  logic        we   [4];
  logic [25:0] din  [4];
  logic [25:0] dout [4];

  assign addr[0] = pix_addr_even;
  assign addr[1] = pix_addr_odd;
  assign addr[2] = pix_addr_even1;
  assign addr[3] = pix_addr_odd1;
  assign we[0]   = pix_we_even;
  assign we[1]   = pix_we_odd;
  assign we[2]   = pix_we_even1;
  assign we[3]   = pix_we_odd1;
  assign din[0]  = pix_din_even;
  assign din[1]  = pix_din_odd;
  assign din[2]  = pix_din_even1;
  assign din[3]  = pix_din_odd1;

  assign pix_dout_even  = dout[0];
  assign pix_dout_odd   = dout[1];
  assign pix_dout_even1 = dout[2];
  assign pix_dout_odd1  = dout[3];

`ifdef RAM_EVEN_LIFT_EN
  logic [25:0] left  [2];
  logic [25:0] right [2];

  assign left[0]  = pix_left;
  assign left[1]  = pix_left1;
  assign right[0] = pix_right;
  assign right[1] = pix_right1;

  // S is formed at 27 bits so L+R cannot overflow; the shifted term is then
  // applied modulo 2^26.
  function automatic logic [25:0] lift(input logic [25:0] x,
                                       input logic [25:0] l,
                                       input logic [25:0] r,
                                       input logic        eo,
                                       input logic        fi);
    logic signed [26:0] s;
    logic signed [26:0] t;
    logic        [25:0] d;
    s = $signed({l[25], l}) + $signed({r[25], r});
    if (eo) t = s >>> 1;
    else    t = (s + 27'sd2) >>> 2;
    d = t[25:0];
    if (eo == fi) lift = x - d;
    else          lift = x + d;
  endfunction
`else
  logic unused_lift;
  assign unused_lift = ^{pix_left, pix_right, pix_left1, pix_right1,
                         pix_even_odd, pix_fwd_inv, pix_p};
`endif

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [25:0] mem [128];
    logic [25:0] wdata;
    logic [25:0] q;

`ifdef RAM_EVEN_LIFT_EN
    always_comb begin
      wdata = din[b];
      if (pix_p)
        wdata = lift(din[b], left[b/2], right[b/2], pix_even_odd, pix_fwd_inv);
    end
`else
    assign wdata = din[b];
`endif

    always_ff @(posedge clk) begin
      if (!rst && we[b]) mem[addr[b]] <= wdata;
    end

    // Read-first: q samples the pre-write contents on the same edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else     q <= mem[addr[b]];
    end

    assign dout[b] = q;
  end

endmodule

// File: tb/tb_ram_even_banks.sv
// Directed self-checking bench for ram_even_banks; expectations follow
// RAM_EVEN_LIFT_EN so the same bench serves both builds.
module tb_ram_even_banks;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  a_e, a_o, a_e1, a_o1;
  logic        w_e, w_o, w_e1, w_o1;
  logic [25:0] d_e, d_o, d_e1, d_o1;
  logic [25:0] q_e, q_o, q_e1, q_o1;
  logic [25:0] l0, r0, l1, r1;
  logic        eo, fi, p;

  int compared = 0;
  int mismatched = 0;

  ram_even_banks dut (
    .clk(clk), .rst(rst),
    .pix_addr_even(a_e), .pix_addr_odd(a_o),
    .pix_addr_even1(a_e1), .pix_addr_odd1(a_o1),
    .pix_we_even(w_e), .pix_we_odd(w_o),
    .pix_we_even1(w_e1), .pix_we_odd1(w_o1),
    .pix_din_even(d_e), .pix_din_odd(d_o),
    .pix_din_even1(d_e1), .pix_din_odd1(d_o1),
    .pix_dout_even(q_e), .pix_dout_odd(q_o),
    .pix_dout_even1(q_e1), .pix_dout_odd1(q_o1),
    .pix_left(l0), .pix_right(r0), .pix_left1(l1), .pix_right1(r1),
    .pix_even_odd(eo), .pix_fwd_inv(fi), .pix_p(p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [25:0] obs,
                       input logic [25:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_we();
    w_e = 1'b0; w_o = 1'b0; w_e1 = 1'b0; w_o1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_e = '0; a_o = '0; a_e1 = '0; a_o1 = '0;
    idle_we();
    d_e = '0; d_o = '0; d_e1 = '0; d_o1 = '0;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    eo = 1'b0; fi = 1'b0; p = 1'b0;

    #3;
    check("rst_even", q_e, 26'h0);
    check("rst_odd", q_o, 26'h0);
    check("rst_even1", q_e1, 26'h0);
    check("rst_odd1", q_o1, 26'h0);
    step();
    rst = 1'b0;

    // Raw write to even @5, read back one cycle after
    a_e = 7'd5; d_e = 26'h0000123; w_e = 1'b1; p = 1'b0;
    step();
    idle_we();
    step();
    check("raw_even5", q_e, 26'h0000123);

    // Forward predict on odd @3: 100 - (100>>>1) = 50
    a_o = 7'd3; d_o = 26'd100; l0 = 26'd40; r0 = 26'd60;
    p = 1'b1; eo = 1'b1; fi = 1'b1; w_o = 1'b1;
    step();
    idle_we();
    step();
`ifdef RAM_EVEN_LIFT_EN
    check("fwd_predict_odd3", q_o, 26'd50);
`else
    check("nolift_odd3", q_o, 26'd100);
`endif

    // Inverse update on even1 @9: 10 - ((-10+2)>>>2) = 12
    a_e1 = 7'd9; d_e1 = 26'd10; l1 = -26'sd4; r1 = -26'sd6;
    p = 1'b1; eo = 1'b0; fi = 1'b0; w_e1 = 1'b1;
    step();
    idle_we();
    step();
`ifdef RAM_EVEN_LIFT_EN
    check("inv_update_even1_9", q_e1, 26'd12);
`else
    check("nolift_even1_9", q_e1, 26'd10);
`endif

    // All four banks @10, forward update: set0 d=(-3+2)>>>2=-1, set1 d=(13+2)>>>2=3
    a_e = 7'd10; a_o = 7'd10; a_e1 = 7'd10; a_o1 = 7'd10;
    d_e = 26'd0; d_o = 26'd5; d_e1 = 26'h1FFFFFE; d_o1 = 26'h3FFFFF9;
    l0 = 26'h3FFFFFD; r0 = 26'd0; l1 = 26'd7; r1 = 26'd6;
    p = 1'b1; eo = 1'b0; fi = 1'b1;
    w_e = 1'b1; w_o = 1'b1; w_e1 = 1'b1; w_o1 = 1'b1;
    step();
    idle_we();
    step();
`ifdef RAM_EVEN_LIFT_EN
    check("all4_even", q_e, 26'h3FFFFFF);
    check("all4_odd", q_o, 26'd4);
    check("all4_even1_wrap", q_e1, 26'h2000001);
    check("all4_odd1", q_o1, 26'h3FFFFFC);
`else
    check("all4_even", q_e, 26'd0);
    check("all4_odd", q_o, 26'd5);
    check("all4_even1", q_e1, 26'h1FFFFFE);
    check("all4_odd1", q_o1, 26'h3FFFFF9);
`endif

    // Read-first at address 127 plus independence from an even write
    p = 1'b0;
    a_o1 = 7'd127; d_o1 = 26'd3; w_o1 = 1'b1;
    step();
    a_e = 7'd127; d_e = 26'd9; w_e = 1'b1; d_o1 = 26'd7;
    step();
    check("readfirst_odd1_old", q_o1, 26'd3);
    idle_we();
    step();
    check("readfirst_odd1_new", q_o1, 26'd7);
    check("even127", q_e, 26'd9);

    // Reset mid-operation with a write pending on every bank
    a_e = 7'd5; a_o = 7'd3; a_e1 = 7'd9; a_o1 = 7'd127;
    step();
    check("pre_rst_even", q_e, 26'h0000123);
    d_e = 26'h1111111; d_o = 26'h2222222; d_e1 = 26'h0333333; d_o1 = 26'h0444444;
    w_e = 1'b1; w_o = 1'b1; w_e1 = 1'b1; w_o1 = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_even", q_e, 26'h0);
    check("async_rst_odd", q_o, 26'h0);
    check("async_rst_even1", q_e1, 26'h0);
    check("async_rst_odd1", q_o1, 26'h0);
    step();
    check("held_rst_even", q_e, 26'h0);
    check("held_rst_odd1", q_o1, 26'h0);
    #2 rst = 1'b0;
    idle_we();
    step();
    check("post_rst_even", q_e, 26'h0000123);
`ifdef RAM_EVEN_LIFT_EN
    check("post_rst_odd", q_o, 26'd50);
    check("post_rst_even1", q_e1, 26'd12);
`else
    check("post_rst_odd", q_o, 26'd100);
    check("post_rst_even1", q_e1, 26'd10);
`endif
    check("post_rst_odd1", q_o1, 26'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_even_banks.md
RAM_EVEN_BANKS -- requirements
Module: ram_even

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. Ports: clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-high reset).
REQ-002 The remaining ports SHALL be, as name / direction / width / meaning:
- pix_addr_even, pix_addr_odd, pix_addr_even1, pix_addr_odd1 / in / 7 / read-write address, one per bank.
- pix_we_even, pix_we_odd, pix_we_even1, pix_we_odd1 / in / 1 / write enable, one per bank.
- pix_din_even, pix_din_odd, pix_din_even1, pix_din_odd1 / in / 26 / write data (sample x), one per bank.
- pix_dout_even, pix_dout_odd, pix_dout_even1, pix_dout_odd1 / out / 26 / registered read data, one per bank.
- pix_left, pix_right / in / 26 / neighbour samples for set 0 (banks even, odd).
- pix_left1, pix_right1 / in / 26 / neighbour samples for set 1 (banks even1, odd1).
- pix_even_odd / in / 1 / lifting step select: 1 = predict (odd step), 0 = update (even step).
- pix_fwd_inv / in / 1 / transform direction: 1 = forward, 0 = inverse.
- pix_p / in / 1 / lifting enable: 1 = write the lifted value, 0 = write din raw.
REQ-003 All data SHALL be 26-bit two's-complement signed.

Function
REQ-004 The block SHALL contain four independent 128x26 single-port memories: even, odd, even1 and odd1.
REQ-005 Writes SHALL take place on the rising clk edge when the bank's we=1, at the bank's address.
REQ-006 Reads SHALL be synchronous: dout SHALL present mem[addr] one cycle after addr is applied, every cycle, regardless of we.
REQ-007 Read during a write to the same address SHALL be read-first: dout returns the old contents.
REQ-008 Write value when pix_p=0: din, unmodified.
REQ-009 Write value when pix_p=1 (lifting), using L/R = pix_left/pix_right for set 0 and pix_left1/pix_right1 for set 1, with S = L+R computed at 27 bits:
- pix_even_odd=1, fwd: x - (S>>>1); inv: x + (S>>>1).
- pix_even_odd=0, fwd: x + ((S+2)>>>2); inv: x - ((S+2)>>>2).
REQ-010 Shifts SHALL be arithmetic, and results SHALL be truncated to 26 bits (wrap, no saturation).
REQ-011 The lifting controls (pix_p, pix_even_odd, pix_fwd_inv) SHALL apply identically to all four banks in the same cycle.
REQ-012 All four banks MAY be written simultaneously with no mutual interaction.
REQ-013 Address wrap SHALL not occur: 7-bit addresses cover exactly 0..127.

Reset
REQ-014 While rst=1, all four dout registers SHALL be 0, asynchronously.
REQ-015 Memory contents SHALL NOT be cleared by reset.
REQ-016 Writes SHALL be suppressed while rst=1.
REQ-017 After rst deasserts, the first clk edge SHALL resume normal read/write operation.
REQ-018 Asserting rst mid-operation SHALL abort any write pending on that edge.

Configuration
REQ-019 Macro RAM_EVEN_LIFT_EN:
- Defined: the lifting datapath of REQ-009 and REQ-010 is present.
- Undefined: pix_p, pix_even_odd, pix_fwd_inv, pix_left*, pix_right* SHALL be ignored and every write SHALL store din raw.

Verification
REQ-020 Raw write/read: write 0x0000123 to even @5 with pix_p=0; read @5 -> pix_dout_even=0x0000123 one cycle after the address is applied.
REQ-021 Forward predict: odd bank, pix_p=1, even_odd=1, fwd=1, x=100, L=40, R=60; write then read -> 50.
REQ-022 Inverse update: even1 bank, pix_p=1, even_odd=0, fwd=0, x=10, L1=-4, R1=-6; write then read -> 12. This uses (-10+2)>>>2 = -2.
REQ-023 Read-first and bank independence:
- Write 7 to odd1 @127 while reading @127 holding old value 3 -> dout=3 that cycle, then 7.
- A simultaneous write of 9 to even @127 SHALL leave odd1 unaffected.
REQ-024 Reset mid-operation: assert rst asynchronously between edges -> all four douts become 0 immediately, the we pulse during reset stores nothing, and previously written data reads back intact after release.
REQ-025 Macro off: RAM_EVEN_LIFT_EN undefined, pix_p=1, x=100 -> stored value 100.
